csa_serial_add_ctrl: RTL and testbench
======================================

// Module: csa_serial_add_ctrl
// PURPOSE
//  Sequencer that reuses one 4-bit carry-select adder slice (carry_select_adder_2) for WIDTH-bit additions.
//  - Processes one nibble per cycle, LSB first, carrying cout into the next nibble.
//  - Operands enter through a valid/ready input handshake; the result leaves through a valid/ready output handshake.
//  - Used where area matters more than latency; one shared slice replaces WIDTH/4 slices.
// PARAMETERS
//  WIDTH   16   operand/sum width; must be a multiple of 4 and >= 8
//  NSLICE  WIDTH/4   derived (localparam), number of nibble steps
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands a/b/cin valid
//  in_ready   out  1      controller can accept operands (high only in IDLE)
//  a          in   WIDTH  operand A, sampled on input handshake
//  b          in   WIDTH  operand B, sampled on input handshake
//  cin        in   1      carry-in, sampled on input handshake
//  out_valid  out  1      sum/cout valid (high only in DONE)
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  registered result
//  cout       out  1      registered carry-out of bit WIDTH-1
//  busy       out  1      high in RUN or DONE
//  ovf        out  1      signed overflow (only when CSA_OVF_EN defined)
// BEHAVIOUR
//  Reset (rst_n low, takes effect immediately):
//  - state=IDLE; idx=0; carry reg=0; a/b regs=0; sum=0; cout=0; ovf=0; out_valid=0; busy=0.
//  - in_ready=1 during and after reset, because it is decoded from IDLE.
//  FSM IDLE -> RUN -> DONE -> IDLE:
//  - IDLE: in_ready=1. On in_valid&in_ready, latch a, b and cin (cin into the carry reg), set idx=0, go to RUN.
//  - RUN: the slice receives a[4*idx+:4], b[4*idx+:4] and the carry reg. Each clock:
//    - sum[4*idx+:4] <= slice sum; carry reg <= slice cout; idx++.
//    - When idx==NSLICE-1: cout <= slice cout and go to DONE.
//  - DONE: out_valid=1. Hold sum, cout and ovf stable. On out_valid&out_ready go to IDLE.
//  Timing:
//  - Latency: out_valid rises NSLICE clocks after the input-handshake edge.
//  - Back-to-back period is NSLICE+2 clocks. There is no accept in the same cycle as the output handshake.
//  - in_valid is ignored outside IDLE; a/b/cin changes during RUN have no effect.
//  After the output handshake:
//  - sum and cout keep their last value until overwritten by the next operation.
//  - The upper nibbles of sum update progressively during RUN; they are valid only while out_valid=1.
//  Arithmetic: {cout,sum} == a + b + cin, modulo 2^(WIDTH+1), with no truncation of the carry.
//  Reset mid-RUN or mid-DONE: abort immediately to the reset values. The partial result is discarded and no out_valid pulse occurs.
//  The slice is purely combinational. All outputs are registered except in_ready and busy, which are decoded from state.
// CONFIGURATION
//  CSA_OVF_EN defined:
//  - ovf register updated on the RUN->DONE edge as a[W-1]^b[W-1]^sum[W-1]^cout (carry-in to MSB xor carry-out).
//  - Reset value of ovf is 0; it is held like sum.
//  CSA_OVF_EN undefined: ovf port and its logic are absent; all other behaviour is unchanged.
// TESTING (WIDTH=16)
//  - 0x1234+0x0001, cin=0 -> sum=0x1235, cout=0; out_valid exactly 4 clocks after accept.
//  - 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1 (carry ripples through all 4 steps). Also 0xFFFF+0xFFFF, cin=1 -> 0xFFFF, cout=1.
//  - 0x7FFF+0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1 (CSA_OVF_EN). 0x8000+0x8000 -> 0x0000, cout=1, ovf=1.
//  - Backpressure: out_ready=0 for 5 clocks in DONE -> out_valid/sum/cout held, in_ready=0, in_valid pulses ignored.
//  - rst_n pulsed low at idx=2 in RUN -> immediately IDLE, out_valid=0, sum=0. Next op 0x00FF+0x0001 -> 0x0100.
//  - Random streams, in_valid and out_ready held 1 -> each result matches a+b+cin; one result every 6 clocks.

Source files
------------

// File: rtl/csa_serial_add_ctrl.sv
// Serial WIDTH-bit adder: one shared 4-bit carry-select slice, one nibble per clock, LSB first.
// Optional signed-overflow output is enabled by defining CSA_OVF_EN.

module carry_select_adder_2 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);
    logic [2:0] lo;
    logic [2:0] hi0;
    logic [2:0] hi1;

    // Upper pair is precomputed for both carries and picked by the lower pair's carry.
    assign lo  = {1'b0, a_i[1:0]} + {1'b0, b_i[1:0]} + {2'b00, cin_i};
    assign hi0 = {1'b0, a_i[3:2]} + {1'b0, b_i[3:2]};
    assign hi1 = {1'b0, a_i[3:2]} + {1'b0, b_i[3:2]} + 3'd1;

    assign sum_o  = {(lo[2] ? hi1[1:0] : hi0[1:0]), lo[1:0]};
    assign cout_o = lo[2] ? hi1[2] : hi0[2];
endmodule

module csa_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef CSA_OVF_EN
   ,output logic             ovf
`endif
);
    localparam int NSLICE = WIDTH / 4;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
            $error("csa_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                 state_q;
    logic [IDX_W-1:0]       idx_q;
    logic                   carry_q;
    logic [NSLICE-1:0][3:0] a_q;
    logic [NSLICE-1:0][3:0] b_q;
    logic [NSLICE-1:0][3:0] sum_q;
    logic                   cout_q;
    logic                   out_valid_q;
`ifdef CSA_OVF_EN
    logic                   ovf_q;
`endif

    logic [3:0] slice_sum;
    logic       slice_cout;

    carry_select_adder_2 u_slice (
        .a_i    (a_q[idx_q]),
        .b_i    (b_q[idx_q]),
        .cin_i  (carry_q),
        .sum_o  (slice_sum),
        .cout_o (slice_cout)
    );

    // NOTE: every register here, including the operand and sum arrays, is reset so an
    // aborted operation leaves no stale data visible; state is updated with <= only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef CSA_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        idx_q   <= '0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_q[idx_q] <= slice_sum;
                    carry_q      <= slice_cout;
                    idx_q        <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        idx_q       <= '0;
                        cout_q      <= slice_cout;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
`ifdef CSA_OVF_EN
                        // Carry into the MSB xor carry out of it.
                        ovf_q <= a_q[NSLICE-1][3] ^ b_q[NSLICE-1][3] ^ slice_sum[3] ^ slice_cout;
`endif
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef CSA_OVF_EN
    assign ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_csa_serial_add_ctrl.sv
// Scoreboard bench for csa_serial_add_ctrl: driver pushes expected results, a negedge monitor
// pops and compares them; directed corner cases, backpressure, mid-run reset and random streams.

module tb_csa_serial_add_ctrl;
    localparam int WIDTH  = 16;
    localparam int NSLICE = WIDTH / 4;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef CSA_OVF_EN
    logic             ovf;
`endif

    csa_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
`ifdef CSA_OVF_EN
       ,.ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t exp_q[$];
    int   acc_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   ov_prev  = 1'b0;
    bit   stream_mode = 1'b0;
    int   stream_rises = 0;
    int   last_rise = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired, required event never seen (t=%0t)", name, $time);
    endtask

    // Reference: plain integer arithmetic, signed overflow as a range test.
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
        exp_t   e;
        longint us;
        longint ss;
        longint smax;
        longint smin;
        us   = longint'(x) + longint'(y) + longint'(c);
        ss   = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
        smax = (longint'(1) <<< (WIDTH - 1)) - 1;
        smin = -(longint'(1) <<< (WIDTH - 1));
        e.sum  = us[WIDTH-1:0];
        e.cout = us[WIDTH];
        e.ovf  = (ss > smax) || (ss < smin);
        return e;
    endfunction

    task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c,
                        input bit expect_it, input bit hold);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = in_ready;
        end
        if (!got) begin
            fail_timeout("in_ready_wait");
            return;
        end
        a        = x;
        b        = y;
        cin      = c;
        in_valid = 1'b1;
        if (expect_it) begin
            exp_q.push_back(model(x, y, c));
            acc_q.push_back(cyc + 1);
        end
        @(posedge clk);
        #1;
        if (hold) begin
            a   = WIDTH'($urandom);
            b   = WIDTH'($urandom);
            cin = 1'($urandom);
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            done = (exp_q.size() == 0);
        end
        if (!done) fail_timeout(name);
    endtask

    // Monitor: latency/period on out_valid rise, result compare on output handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            ov_prev = 1'b0;
        end else begin
            if (out_valid && !ov_prev) begin
                if (acc_q.size() == 0) begin
                    fail_timeout("unexpected_out_valid_rise");
                end else begin
                    check("latency", 64'(cyc - acc_q.pop_front()), 64'(NSLICE));
                end
                if (stream_mode) begin
                    if (stream_rises > 0)
                        check("stream_period", 64'(cyc - last_rise), 64'(NSLICE + 2));
                    stream_rises++;
                    last_rise = cyc;
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    fail_timeout("unexpected_output");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sum", 64'(sum), 64'(e.sum));
                    check("cout", 64'(cout), 64'(e.cout));
`ifdef CSA_OVF_EN
                    check("ovf", 64'(ovf), 64'(e.ovf));
`endif
                end
            end
            ov_prev = out_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t bp;
        bit   seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed corner cases.
        send(16'h1234, 16'h0001, 1'b0, 1'b1, 1'b0);
        send(16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0);
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0);
        send(16'h8000, 16'h8000, 1'b0, 1'b1, 1'b0);
        wait_drain("drain_directed");

        // Backpressure: result held for 5 clocks while in_valid pulses are ignored.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        bp = model(16'h0F0F, 16'h0101, 1'b0);
        send(16'h0F0F, 16'h0101, 1'b0, 1'b1, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        if (!seen) fail_timeout("bp_out_valid_wait");
        for (int k = 0; k < 5; k++) begin
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_busy", 64'(busy), 64'd1);
            check("bp_sum", 64'(sum), 64'(bp.sum));
            check("bp_cout", 64'(cout), 64'(bp.cout));
            in_valid = 1'b1;
            a        = 16'hFFFF;
            b        = 16'hFFFF;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain("drain_bp");
        repeat (10) @(negedge clk);
        check("bp_no_extra_op", 64'(busy), 64'd0);

        // Reset while idx==2 in RUN: partial result discarded immediately.
        send(16'hABCD, 16'h1111, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_sum", 64'(sum), 64'd0);
        check("midrst_cout", 64'(cout), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(16'h00FF, 16'h0001, 1'b0, 1'b1, 1'b0);
        wait_drain("drain_after_rst");

        // Random single operations.
        for (int i = 0; i < 8; i++)
            send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b1, 1'b0);
        wait_drain("drain_random");

        // Random stream with in_valid and out_ready held high.
        @(posedge clk);
        #1;
        stream_mode  = 1'b1;
        stream_rises = 0;
        for (int i = 0; i < 20; i++)
            send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b1, 1'b1);
        in_valid = 1'b0;
        wait_drain("drain_stream");
        repeat (NSLICE + 4) @(negedge clk);
        stream_mode = 1'b0;
        check("stream_results", 64'(stream_rises), 64'd20);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
